// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO producer/consumer slice.
//   LIFO_DATA_W  : default data word width, shared with the LIFO itself
//   prod_state_e : producer thread state encoding
package lifo_pkg;

    localparam int unsigned LIFO_DATA_W = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_GAP   = 2'd3
    } prod_state_e;

endpackage

// File: rtl/lifo_producer_sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into clock_p.
//   clock_p : destination clock
//   reset   : asynchronous active-high reset, clears both flops to 0
//   d_i     : asynchronous input level
//   q_o     : synchronized level, two clock_p edges behind d_i
module sync_2ff (
    input  logic clock_p,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock_p or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/lifo_producer.sv
// Producer thread for the LIFO write side.
// Takes words from a valid/ready stream, waits (bounded) for the LIFO to be
// non-full, then issues a single-cycle write strobe followed by a mandatory
// low cycle. Words that cannot be pushed within TIMEOUT cycles are dropped.
//   clock_p       : producer clock
//   reset         : asynchronous active-high reset
//   enable        : allow acceptance of new words
//   src_valid/src_data/src_ready : upstream stream
//   full          : LIFO full flag (asynchronous, synchronized internally)
//   write/datain  : LIFO write strobe and data
//   busy          : a word is in flight
//   drop          : one-cycle pulse when a word is discarded
//   written_count/drop_count : saturating statistics
module lifo_producer
    import lifo_pkg::*;
#(
    parameter int unsigned DATA_W  = LIFO_DATA_W,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clock_p,
    input  logic               reset,
    input  logic               enable,
    input  logic               src_valid,
    input  logic [DATA_W-1:0]  src_data,
    output logic               src_ready,
    input  logic               full,
    output logic               write,
    output logic [DATA_W-1:0]  datain,
    output logic               busy,
    output logic               drop,
    output logic [COUNT_W-1:0] written_count,
    output logic [COUNT_W-1:0] drop_count
);

    localparam int unsigned TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    prod_state_e        state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [DATA_W-1:0]  datain_q;
    logic               write_q;
    logic               drop_q;
    logic               busy_q;
    logic [COUNT_W-1:0] written_q;
    logic [COUNT_W-1:0] written_d;
    logic [COUNT_W-1:0] dropped_q;
    logic [COUNT_W-1:0] dropped_d;
    logic               full_s;

    sync_2ff u_full_sync (
        .clock_p (clock_p),
        .reset   (reset),
        .d_i     (full),
        .q_o     (full_s)
    );

    // Saturating next values; counters stick at all-ones.
    always_comb begin
        written_d = (written_q == '1) ? written_q : written_q + 1'b1;
        dropped_d = (dropped_q == '1) ? dropped_q : dropped_q + 1'b1;
    end

    assign src_ready = (state_q == S_IDLE) && enable && !reset;

    always_ff @(posedge clock_p or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            datain_q  <= '0;
            write_q   <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
            written_q <= '0;
            dropped_q <= '0;
        end else begin
            write_q <= 1'b0;
            drop_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (src_valid && src_ready) begin
                        datain_q <= src_data;
                        timer_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // full_s is checked before the timeout, so a release seen
                    // on the last wait cycle still gets the word written.
                    if (!full_s) begin
                        write_q   <= 1'b1;
                        written_q <= written_d;
                        state_q   <= S_WRITE;
                    end else if (timer_q == TIMER_LAST) begin
                        drop_q    <= 1'b1;
                        dropped_q <= dropped_d;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign write         = write_q;
    assign datain        = datain_q;
    assign busy          = busy_q;
    assign drop          = drop_q;
    assign written_count = written_q;
    assign drop_count    = dropped_q;

endmodule

// File: tb/tb_lifo_producer.sv
module tb_lifo_producer;

    localparam int unsigned DW  = 10;
    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 8;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          full;
    logic          write;
    logic [DW-1:0] datain;
    logic          busy;
    logic          drop;
    logic [CW-1:0] written_count;
    logic [CW-1:0] drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lifo_producer #(
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .COUNT_W (CW)
    ) dut (
        .clock_p       (clk),
        .reset         (reset),
        .enable        (enable),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .full          (full),
        .write         (write),
        .datain        (datain),
        .busy          (busy),
        .drop          (drop),
        .written_count (written_count),
        .drop_count    (drop_count)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural reference: timestamps per word in flight.
    // A word accepted at edge acc is written at the first later edge whose
    // synchronized full is 0 (full as it stood two edges earlier), unless
    // TIMEOUT edges pass first, in which case it is dropped. After a write
    // edge w the producer is idle again from edge w+2.
    int          n;
    bit          inflight;
    int          acc;
    int          wr;
    logic [DW-1:0] word;
    int          wcnt;
    int          dcnt;
    bit          f1, f2;
    bit          write_m, drop_m;

    always @(posedge clk) begin
        bit v, en, fs, fnow;
        logic [DW-1:0] d;
        v = src_valid; en = enable; d = src_data; fnow = full;
        write_m = 1'b0;
        drop_m  = 1'b0;
        if (reset) begin
            n = 0; inflight = 0; acc = 0; wr = -1; word = '0;
            wcnt = 0; dcnt = 0; f1 = 0; f2 = 0;
        end else begin
            fs = f2;
            if (!inflight) begin
                if (v && en) begin
                    inflight = 1; acc = n; word = d; wr = -1;
                end
            end else if (wr < 0) begin
                if (!fs) begin
                    wr = n; write_m = 1'b1;
                    wcnt = (wcnt == CMAX) ? wcnt : wcnt + 1;
                end else if (n - acc == TO) begin
                    drop_m = 1'b1; inflight = 0;
                    dcnt = (dcnt == CMAX) ? dcnt : dcnt + 1;
                end
            end else if (n == wr + 2) begin
                inflight = 0;
            end
            f2 = f1; f1 = fnow;
            n++;
        end
        #1;
        chk("write",     32'(write),         32'(write_m));
        chk("drop",      32'(drop),          32'(drop_m));
        chk("busy",      32'(busy),          32'(inflight));
        chk("datain",    32'(datain),        32'(word));
        chk("wcount",    32'(written_count), 32'(wcnt));
        chk("dcount",    32'(drop_count),    32'(dcnt));
        chk("src_ready", 32'(src_ready),     32'(!inflight && enable && !reset));
    end

    task automatic cyc(int k);
        repeat (k) @(negedge clk);
    endtask

    // Present w and wait (bounded) until it is accepted; returns at the
    // negedge just after the accepting edge. src_valid stays high.
    task automatic push(logic [DW-1:0] w);
        bit ok;
        ok = 0;
        src_valid = 1'b1;
        src_data  = w;
        for (int i = 0; i < 60; i++) begin
            if (src_ready) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        int base;
        reset = 1'b1; enable = 1'b1; src_valid = 1'b0; src_data = '0; full = 1'b0;
        cyc(3);
        chk("rst_write",  32'(write),         32'd0);
        chk("rst_datain", 32'(datain),        32'd0);
        chk("rst_busy",   32'(busy),          32'd0);
        chk("rst_ready",  32'(src_ready),     32'd0);
        chk("rst_wcnt",   32'(written_count), 32'd0);
        reset = 1'b0;
        cyc(2);

        // single word, literal timing
        push(10'h011);
        src_valid = 1'b0;
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_w0",   32'(write), 32'd0);
        cyc(1);
        chk("single_w1",   32'(write), 32'd1);
        chk("single_data", 32'(datain), 32'h011);
        cyc(1);
        chk("single_w2",   32'(write), 32'd0);
        chk("single_rdy2", 32'(src_ready), 32'd0);
        cyc(1);
        chk("single_rdy3", 32'(src_ready), 32'd1);
        chk("single_wcnt", 32'(written_count), 32'd1);
        chk("single_dcnt", 32'(drop_count), 32'd0);

        // burst
        push(10'h0AA); push(10'h0BB); push(10'h0CC); push(10'h0DD);
        src_valid = 1'b0;
        cyc(5);
        chk("burst_wcnt", 32'(written_count), 32'd5);
        chk("burst_data", 32'(datain), 32'h0DD);

        // stuck full -> drop 16 cycles after entering WAIT
        full = 1'b1;
        cyc(3);
        push(10'h0EE);
        src_valid = 1'b0;
        cnt = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (drop) begin cnt = i; break; end
        end
        chk("stuck_drop_delay", 32'(cnt), 32'd16);
        chk("stuck_dcnt", 32'(drop_count), 32'd1);
        chk("stuck_data", 32'(datain), 32'h0EE);
        chk("stuck_ready", 32'(src_ready), 32'd1);
        chk("stuck_wcnt", 32'(written_count), 32'd5);

        // full released after 5 cycles
        push(10'h055);
        src_valid = 1'b0;
        cyc(5);
        full = 1'b0;
        cnt = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (write) begin cnt = i; break; end
        end
        chk("release_delay", 32'(cnt), 32'd3);
        chk("release_data", 32'(datain), 32'h055);
        cyc(3);
        chk("release_dcnt", 32'(drop_count), 32'd1);
        chk("release_wcnt", 32'(written_count), 32'd6);

        // reset while write is high
        push(10'h066);
        src_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && !write; i++) @(negedge clk);
        chk("midrst_pre_write", 32'(write), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_write",  32'(write), 32'd0);
        chk("midrst_datain", 32'(datain), 32'd0);
        chk("midrst_busy",   32'(busy), 32'd0);
        chk("midrst_wcnt",   32'(written_count), 32'd0);
        chk("midrst_dcnt",   32'(drop_count), 32'd0);
        chk("midrst_ready",  32'(src_ready), 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        push(10'h077);
        src_valid = 1'b0;
        cyc(5);
        chk("postrst_wcnt", 32'(written_count), 32'd1);
        chk("postrst_data", 32'(datain), 32'h077);

        // enable gating
        enable = 1'b0; src_valid = 1'b1; src_data = 10'h033;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("gate_ready", 32'(src_ready), 32'd0);
        end
        chk("gate_wcnt", 32'(written_count), 32'd1);
        enable = 1'b1;
        cyc(1);
        src_valid = 1'b0;
        cyc(5);
        chk("gate_after_wcnt", 32'(written_count), 32'd2);
        chk("gate_after_data", 32'(datain), 32'h033);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            src_valid = ($urandom_range(9) < 7);
            src_data  = DW'($urandom);
            enable    = ($urandom_range(9) != 0);
            if ($urandom_range(19) == 0) full = ~full;
        end

        // written_count saturation
        full = 1'b0; enable = 1'b1; src_valid = 1'b1;
        cyc(1200);
        chk("wcnt_sat", 32'(written_count), 32'(CMAX));
        base = drop_count;

        // drop_count saturation
        full = 1'b1;
        cyc(4400);
        chk("dcnt_sat", 32'(drop_count), 32'(CMAX));
        chk("wcnt_hold", 32'(written_count), 32'(CMAX));
        src_valid = 1'b0; full = 1'b0;
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
